button_debounce_bank: RTL and testbench
=======================================

// Module: button_debounce_bank
// PURPOSE
//  N_CH-channel push-button front end: 2-FF synchroniser, per-channel debounce counter,
//  registered stable level plus one-cycle press/release strobes. Sits between board pins
//  (xBTNn) and the control FSMs in top. Replaces ad-hoc per-button debouncers.
//  Generalised in channel count, debounce time and input polarity; optional hold auto-repeat.
// PARAMETERS
//  N_CH          4      number of independent button channels
//  DEB_CYCLES    50000  stable cycles required to accept a new level (>=1)
//  CNT_W         16     debounce counter width; must satisfy 2**CNT_W > DEB_CYCLES
//  ACTIVE_LOW    0      1: pin low = pressed (input inverted before synchroniser)
//  REPEAT_DELAY  6000000 held cycles after press before first repeat (repeat build only)
//  REPEAT_PERIOD 1200000 cycles between subsequent repeats (repeat build only)
//  REP_W         24     repeat counter width; 2**REP_W > max(REPEAT_DELAY,REPEAT_PERIOD)
// PORTS
//  clk          in   1     system clock; all state on rising edge
//  rst          in   1     asynchronous, active-high reset
//  btn_in       in   N_CH  raw, asynchronous button pins
//  btn_state    out  N_CH  debounced level, 1 = pressed
//  btn_press    out  N_CH  1-cycle strobe, cycle btn_state first reads 1
//  btn_release  out  N_CH  1-cycle strobe, cycle btn_state first reads 0
//  btn_repeat   out  N_CH  1-cycle auto-repeat strobe (0 when feature compiled out)
// BEHAVIOUR
//  - Reset (async assert, sync release): sync FFs, counters, btn_state, all strobes = 0.
//  - Polarity: lvl = ACTIVE_LOW ? ~btn_in : btn_in; s1<=lvl, s2<=s1 (per channel).
//  - Per channel each edge: if s2==state: cnt<=0. Else if cnt==DEB_CYCLES-1: state<=s2,
//    cnt<=0, strobe press (s2=1) or release (s2=0). Else cnt<=cnt+1.
//  - Latency: new level first sampled by s1 at edge 0 and held -> btn_state and strobe
//    change at edge DEB_CYCLES+1. Strobes registered, high exactly one cycle.
//  - Bounce: any cycle with s2==state clears cnt; pulses/gaps < DEB_CYCLES never toggle
//    state. Flip of state on the counting edge needs no extra stable cycle.
//  - Channels fully independent; simultaneous events give simultaneous strobes.
//  - press and release never both high on one channel in one cycle.
//  - Reset mid-count: count discarded, no strobe; held button after release of rst yields
//    btn_press at edge DEB_CYCLES+1 after first sampling edge.
//  - Counters saturate never: reaching DEB_CYCLES-1 always resolves or clears.
// CONFIGURATION
//  Macro DEBOUNCE_REPEAT_EN:
//  - Defined: per-channel hold counter rc (REP_W). Press strobe loads rc<=0; while
//    btn_state=1 rc increments; btn_repeat strobes when rc==REPEAT_DELAY-1 (first) then
//    every REPEAT_PERIOD cycles thereafter (rc reloads to REPEAT_DELAY-REPEAT_PERIOD).
//    Release or rst clears rc; no repeat in release cycle. Repeat never coincides with press.
//  - Undefined: btn_repeat tied 4'b0/N_CH zeros, no repeat logic synthesised;
//    REPEAT_* and REP_W ignored.
// TESTING  (N_CH=4, DEB_CYCLES=8, ACTIVE_LOW=0 unless noted)
//  1 rst=1 with btn_in=4'hF -> all outputs 0 throughout; rst=0, hold -> btn_press=4'hF
//    single cycle at edge 9 after first sample, btn_state=4'hF after.
//  2 ch0 toggles every 3 cycles for 24 cycles then stays 1 -> exactly one btn_press[0],
//    9 edges after final rising edge sampled; no release strobe.
//  3 ch1 high 7 cycles then low -> no strobe, btn_state[1]=0; high 8+ -> press.
//  4 ch2 pressed then released after 50 cycles -> btn_release[2] one cycle at edge 9
//    after release sampled, btn_state[2]=0; btn_press/release never overlap.
//  5 ch0+ch3 rise same cycle, rst pulsed mid-count on ch1 -> press[0],[3] same cycle,
//    ch1 no strobe; ACTIVE_LOW=1 with btn_in=4'hF idle -> no activity.
//  6 DEBOUNCE_REPEAT_EN, REPEAT_DELAY=20, REPEAT_PERIOD=5, ch0 held 40 cycles after
//    press -> btn_repeat[0] at press+20,+25,+30,+35; none after release;
//    macro undefined -> btn_repeat==0 always.

Source files
------------

// File: rtl/button_debounce_bank.sv
// button_debounce_bank: N_CH push-button front end.
// Each channel has a polarity fix, a 2-FF synchroniser and a debounce counter.
// It produces a registered stable level and one-cycle press and release strobes.
// Optional hold auto-repeat is built only when DEBOUNCE_REPEAT_EN is defined.
// Without that macro, btn_repeat is tied to zero and the REPEAT_* / REP_W
// parameters have no effect.

module button_debounce_bank_ch #(
    parameter int DEB_CYCLES    = 50000,
    parameter int CNT_W         = 16,
    parameter int ACTIVE_LOW    = 0
`ifdef DEBOUNCE_REPEAT_EN
   ,parameter int REPEAT_DELAY  = 6000000,
    parameter int REPEAT_PERIOD = 1200000,
    parameter int REP_W         = 24
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic state,
    output logic press,
    output logic rel,
    output logic rpt
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             lvl;
    logic             s1, s2;
    logic [CNT_W-1:0] cnt;
    logic             flip;

    assign lvl  = (ACTIVE_LOW != 0) ? ~pin : pin;
    // The synchronised level has disagreed with state for DEB_CYCLES edges in a row.
    assign flip = (s2 != state) && (cnt == CNT_LAST);

    // Synchroniser, debounce counter, stable level and edge strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            state <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            s1    <= lvl;
            s2    <= s1;
            press <= 1'b0;
            rel   <= 1'b0;
            if (s2 == state) begin
                cnt <= '0;
            end else if (flip) begin
                state <= s2;
                cnt   <= '0;
                press <= s2;
                rel   <= ~s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef DEBOUNCE_REPEAT_EN
    localparam logic [REP_W-1:0] RC_FIRST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] RC_RELOAD = REP_W'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [REP_W-1:0] rc;

    // Hold timer. It stays cleared while the button is released, including the
    // press edge (state is still 0 then) and the release edge (flip with state=1).
    // The reload value makes every later repeat land REPEAT_PERIOD cycles apart.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rc  <= '0;
            rpt <= 1'b0;
        end else begin
            rpt <= 1'b0;
            if (!state || flip) begin
                rc <= '0;
            end else if (rc == RC_FIRST) begin
                rpt <= 1'b1;
                rc  <= RC_RELOAD;
            end else begin
                rc <= rc + 1'b1;
            end
        end
    end
`else
    assign rpt = 1'b0;
`endif

endmodule

module button_debounce_bank #(
    parameter int N_CH          = 4,
    parameter int DEB_CYCLES    = 50000,
    parameter int CNT_W         = 16,
    parameter int ACTIVE_LOW    = 0
`ifdef DEBOUNCE_REPEAT_EN
   ,parameter int REPEAT_DELAY  = 6000000,
    parameter int REPEAT_PERIOD = 1200000,
    parameter int REP_W         = 24
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_state,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release,
    output logic [N_CH-1:0] btn_repeat
);
    // Reject configurations where the counter cannot reach its terminal value.
    if (DEB_CYCLES < 1) begin : g_bad_deb
        $error("DEB_CYCLES must be >= 1");
    end
    if ((64'd1 << CNT_W) <= 64'(DEB_CYCLES)) begin : g_bad_cnt_w
        $error("CNT_W too narrow for DEB_CYCLES");
    end
`ifdef DEBOUNCE_REPEAT_EN
    if (REPEAT_PERIOD < 1 || REPEAT_DELAY < REPEAT_PERIOD) begin : g_bad_rep
        $error("need 1 <= REPEAT_PERIOD <= REPEAT_DELAY");
    end
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        button_debounce_bank_ch #(
            .DEB_CYCLES    (DEB_CYCLES),
            .CNT_W         (CNT_W),
            .ACTIVE_LOW    (ACTIVE_LOW)
`ifdef DEBOUNCE_REPEAT_EN
           ,.REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD),
            .REP_W         (REP_W)
`endif
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .pin   (btn_in[i]),
            .state (btn_state[i]),
            .press (btn_press[i]),
            .rel   (btn_release[i]),
            .rpt   (btn_repeat[i])
        );
    end

endmodule

// File: tb/tb_button_debounce_bank.sv
// Directed bench for button_debounce_bank (N_CH=4, DEB_CYCLES=8).
// Two DUTs are driven with complementary pins.
// - dut uses active-high polarity.
// - dut_al uses active-low polarity.
// Both must match one window-based model on every cycle. Literal checks pin
// the strobe timing.
module tb_button_debounce_bank;
    localparam int N   = 4;
    localparam int DEB = 8;
    localparam int RD  = 20;
    localparam int RP  = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] btn = '0;
    logic [N-1:0] btn_n;
    logic [N-1:0] st, pr, rl, rp;
    logic [N-1:0] st_al, pr_al, rl_al, rp_al;

    assign btn_n = ~btn;
    always #5 clk = ~clk;

    button_debounce_bank #(.N_CH(N), .DEB_CYCLES(DEB), .CNT_W(4), .ACTIVE_LOW(0)
`ifdef DEBOUNCE_REPEAT_EN
        , .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REP_W(8)
`endif
    ) dut (.clk(clk), .rst(rst), .btn_in(btn), .btn_state(st), .btn_press(pr),
           .btn_release(rl), .btn_repeat(rp));

    button_debounce_bank #(.N_CH(N), .DEB_CYCLES(DEB), .CNT_W(4), .ACTIVE_LOW(1)
`ifdef DEBOUNCE_REPEAT_EN
        , .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REP_W(8)
`endif
    ) dut_al (.clk(clk), .rst(rst), .btn_in(btn_n), .btn_state(st_al), .btn_press(pr_al),
              .btn_release(rl_al), .btn_repeat(rp_al));

    int nvec = 0;
    int nbad = 0;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nbad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state
    // hist[j] holds the pin level seen j+1 edges ago.
    // A channel flips when all DEB synchronised samples in its window disagree
    // with the current level.
    logic [N-1:0] hist [0:DEB];
    logic [N-1:0] m_st = '0, m_pr = '0, m_rl = '0, m_rp = '0;
    int cyc = 0;
    int press_cyc [N];
    int cnt_pr [N], cnt_rl [N], cnt_rp [N];
    int last_pr [N], last_rl [N], first_rp [N], last_rp [N];

    initial for (int j = 0; j <= DEB; j++) hist[j] = '0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_st = '0; m_pr = '0; m_rl = '0; m_rp = '0;
            for (int j = 0; j <= DEB; j++) hist[j] = '0;
        end else begin
            m_pr = '0; m_rl = '0; m_rp = '0;
            for (int c = 0; c < N; c++) begin
                bit all_diff;
                int n;
                all_diff = 1'b1;
                for (int j = 1; j <= DEB; j++)
                    if (hist[j][c] == m_st[c]) all_diff = 1'b0;
                if (all_diff) begin
                    if (m_st[c]) m_rl[c] = 1'b1;
                    else begin m_pr[c] = 1'b1; press_cyc[c] = cyc; end
                    m_st[c] = ~m_st[c];
                end else if (m_st[c]) begin
                    n = cyc - press_cyc[c];
`ifdef DEBOUNCE_REPEAT_EN
                    m_rp[c] = (n >= RD) && ((n - RD) % RP == 0);
`else
                    m_rp[c] = (n < 0);
`endif
                end
            end
            for (int j = DEB; j >= 1; j--) hist[j] = hist[j-1];
            hist[0] = btn;
        end
        #1;
        chk("state", int'(st), int'(m_st));
        chk("press", int'(pr), int'(m_pr));
        chk("release", int'(rl), int'(m_rl));
        chk("repeat", int'(rp), int'(m_rp));
        chk("al_state", int'(st_al), int'(m_st));
        chk("al_press", int'(pr_al), int'(m_pr));
        chk("al_release", int'(rl_al), int'(m_rl));
        chk("al_repeat", int'(rp_al), int'(m_rp));
        for (int c = 0; c < N; c++) begin
            if (pr[c]) begin cnt_pr[c]++; last_pr[c] = cyc; end
            if (rl[c]) begin cnt_rl[c]++; last_rl[c] = cyc; end
            if (rp[c]) begin
                if (cnt_rp[c] == 0) first_rp[c] = cyc;
                cnt_rp[c]++; last_rp[c] = cyc;
            end
        end
    end

    task automatic clr();
        for (int c = 0; c < N; c++) begin
            cnt_pr[c] = 0; cnt_rl[c] = 0; cnt_rp[c] = 0;
            last_pr[c] = -1; last_rl[c] = -1; first_rp[c] = -1; last_rp[c] = -1;
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int c0;
        clr();
        // Test 1: reset held with all pins pressed, then released while held.
        btn = 4'hF;
        cycles(5);
        chk("rst_state", int'(st), 0);
        rst = 1'b0;
        c0 = cyc;
        cycles(12);
        for (int c = 0; c < N; c++) begin
            chk("t1_press_cnt", cnt_pr[c], 1);
            chk("t1_press_cyc", last_pr[c], c0 + 10);
        end
        chk("t1_state", int'(st), 15);
        btn = '0;
        cycles(12);

        // Test 2: ch0 bounces with 3-cycle pulses, then settles high.
        clr();
        for (int i = 0; i < 8; i++) begin
            btn[0] = (i % 2 == 0);
            cycles(3);
        end
        btn[0] = 1'b1;
        c0 = cyc;
        cycles(12);
        chk("t2_press_cnt", cnt_pr[0], 1);
        chk("t2_press_cyc", last_pr[0], c0 + 10);
        chk("t2_rel_cnt", cnt_rl[0], 0);
        btn[0] = 1'b0;
        cycles(12);

        // Test 3: a 7-cycle pulse is rejected, an 8-cycle pulse is accepted.
        clr();
        btn[1] = 1'b1; cycles(7); btn[1] = 1'b0; cycles(12);
        chk("t3_short_press", cnt_pr[1], 0);
        chk("t3_short_state", int'(st[1]), 0);
        btn[1] = 1'b1; cycles(8); btn[1] = 1'b0; cycles(12);
        chk("t3_long_press", cnt_pr[1], 1);
        cycles(12);

        // Test 4: ch2 is held for 50 cycles, then released.
        clr();
        btn[2] = 1'b1; cycles(50);
        btn[2] = 1'b0;
        c0 = cyc;
        cycles(12);
        chk("t4_press_cnt", cnt_pr[2], 1);
        chk("t4_rel_cnt", cnt_rl[2], 1);
        chk("t4_rel_cyc", last_rl[2], c0 + 10);
        chk("t4_state", int'(st[2]), 0);

        // Test 5: ch0 and ch3 rise together; then reset lands mid-count on ch1.
        clr();
        btn[0] = 1'b1; btn[3] = 1'b1;
        cycles(12);
        chk("t5_same_cycle", last_pr[3], last_pr[0]);
        chk("t5_pr3_cnt", cnt_pr[3], 1);
        btn = '0; cycles(12);
        clr();
        btn[1] = 1'b1; cycles(5);
        rst = 1'b1; cycles(1);
        rst = 1'b0; btn[1] = 1'b0;
        cycles(12);
        chk("t5_rst_ch1", cnt_pr[1], 0);
        chk("t5_al_idle", int'(st_al), 0);

        // Test 6: ch0 is held through the repeat window, then released.
        clr();
        btn[0] = 1'b1;
        c0 = cyc;
        cycles(38);
        btn[0] = 1'b0;
        cycles(15);
        chk("t6_press_cyc", last_pr[0], c0 + 10);
`ifdef DEBOUNCE_REPEAT_EN
        chk("t6_rep_cnt", cnt_rp[0], 4);
        chk("t6_rep_first", first_rp[0], c0 + 30);
        chk("t6_rep_last", last_rp[0], c0 + 45);
`else
        chk("t6_rep_cnt", cnt_rp[0], 0);
`endif
        chk("t6_rel_cnt", cnt_rl[0], 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
